divisor_clock_prog: RTL and testbench
=====================================

Name: divisor_clock_prog

Overview:
Parametrised clock-enable generator for the digital clock datapath. It divides the board clock down to a 50%-duty square wave and a matching one-cycle `tick`. It supports pause, synchronous clear, and a fast mode used while the user sets the time. A second, independent divider produces a `blink` square wave that drives the display digits flashing in set mode.

Parameters:
CLK_FREQ_HZ, 50000000, input clock frequency in Hz
OUT_FREQ_HZ, 1, frequency of clk_out/tick in normal mode
FAST_FACTOR, 60, speed-up of clk_out/tick when fast=1
BLINK_FREQ_HZ, 2, frequency of blink output

Ports:
clk_in  input  1  system clock, all logic on posedge
rst  input  1  asynchronous active-low reset
en  input  1  1 = main divider runs, 0 = main divider holds (pause)
fast  input  1  1 = use fast half-period
sync_clr  input  1  synchronous clear of all dividers and outputs
clk_out  output  1  square wave, 50% duty, OUT_FREQ_HZ (or xFAST_FACTOR)
tick  output  1  one-cycle pulse, high in the cycle in which clk_out is 1 for the first time each period
blink  output  1  square wave at BLINK_FREQ_HZ, 50% duty

Behaviour:
- Derived constants:
  - HALF = CLK_FREQ_HZ/(2*OUT_FREQ_HZ), integer truncation.
  - HALF_FAST = max(1, HALF/FAST_FACTOR).
  - HALF_BLINK = CLK_FREQ_HZ/(2*BLINK_FREQ_HZ).
- Counter widths are sized by $clog2 of the largest limit; no hard-coded widths.
- Elaboration error if HALF < 1, HALF_BLINK < 1, or FAST_FACTOR < 1.
- Reset (rst=0, asynchronous, no clock needed):
  - both counters = 0
  - clk_out = 0, tick = 0, blink = 0
- Release is synchronous to clk_in; the first count occurs on the first posedge with rst=1.
- Main divider, per posedge, first matching rule wins:
  - sync_clr=1: main counter=0, clk_out=0, tick=0. Has priority over en and fast.
  - en=0: main counter and clk_out hold; tick=0.
  - en=1 and counter >= LIMIT-1, where LIMIT = fast ? HALF_FAST : HALF: counter=0, clk_out toggles. tick=1 only if clk_out goes 0->1, else 0.
  - otherwise: counter+1, tick=0.
- Terminal compare uses >=, never ==. When fast switches 1->0 or 0->1 mid-count with counter already past the new limit, the toggle happens on the very next enabled edge. The counter never wraps through 2^W.
- tick is registered and is never high for two consecutive cycles. When HALF_FAST=1, tick is high every 2nd cycle.
- Blink divider:
  - Runs whenever rst=1; ignores en and fast.
  - Cleared by sync_clr: counter=0, blink=0.
  - At counter == HALF_BLINK-1: counter=0, blink toggles; else counter+1.
- Simultaneous events:
  - sync_clr with a terminal count: clear wins, no toggle, no tick.
  - en falling at a terminal count: hold wins, no toggle.
- Outputs are all registered; no combinational path from inputs to outputs.

Test Plan:
(bench parameters: CLK_FREQ_HZ=20, OUT_FREQ_HZ=1, FAST_FACTOR=5, BLINK_FREQ_HZ=2, so HALF=10, HALF_FAST=2, HALF_BLINK=5)
1. Release rst, en=1, fast=0 -> clk_out rises after posedge 10, falls after 20, rises after 30. tick high exactly in the cycles after posedges 10, 30, 50. blink toggles every 5 cycles.
2. en=0 for 7 cycles starting with main counter=4 -> clk_out/tick edges delayed by exactly 7 cycles. blink unaffected. No tick while paused.
3. fast=1 steady -> clk_out period 4 cycles, tick every 4 cycles, 1 cycle wide.
4. Main counter=7, fast 0->1 -> clk_out toggles on the next posedge; subsequent half-periods are 2 cycles.
5. Assert rst low between clock edges mid-period -> clk_out, tick, blink read 0 before the next posedge. After release, scenario 1 timing repeats.
6. sync_clr=1 for one cycle while en=0 with clk_out=1 -> clk_out=0, both counters 0, blink=0. The next rise occurs 10 enabled cycles later.

Source files
------------

// File: rtl/divisor_clock_prog.sv
// Programmable clock-enable generator: a main divider for clk_out/tick with pause,
// clear and fast modes, and an independent divider producing the blink square wave.
module divisor_clock_prog #(
    parameter int CLK_FREQ_HZ   = 50000000,
    parameter int OUT_FREQ_HZ   = 1,
    parameter int FAST_FACTOR   = 60,
    parameter int BLINK_FREQ_HZ = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic en,
    input  logic fast,
    input  logic sync_clr,
    output logic clk_out,
    output logic tick,
    output logic blink
);

    localparam int HALF       = CLK_FREQ_HZ / (2 * OUT_FREQ_HZ);
    localparam int FAST_DIV   = (FAST_FACTOR < 1) ? 1 : FAST_FACTOR;
    localparam int HALF_FAST  = ((HALF / FAST_DIV) < 1) ? 1 : (HALF / FAST_DIV);
    localparam int HALF_BLINK = CLK_FREQ_HZ / (2 * BLINK_FREQ_HZ);
    localparam int MAIN_W     = (HALF > 1) ? $clog2(HALF) : 1;
    localparam int BLINK_W    = (HALF_BLINK > 1) ? $clog2(HALF_BLINK) : 1;

    localparam logic [MAIN_W-1:0]  HALF_LAST      = MAIN_W'(HALF - 1);
    localparam logic [MAIN_W-1:0]  HALF_FAST_LAST = MAIN_W'(HALF_FAST - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST     = BLINK_W'(HALF_BLINK - 1);

    if (HALF < 1) begin : g_bad_half
        $error("divisor_clock_prog: HALF must be at least 1");
    end
    if (HALF_BLINK < 1) begin : g_bad_blink
        $error("divisor_clock_prog: HALF_BLINK must be at least 1");
    end
    if (FAST_FACTOR < 1) begin : g_bad_fast
        $error("divisor_clock_prog: FAST_FACTOR must be at least 1");
    end

    logic [MAIN_W-1:0]  main_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic [MAIN_W-1:0]  limit_last;

    always_comb begin
        limit_last = fast ? HALF_FAST_LAST : HALF_LAST;
    end

    // Terminal test uses >= so a switch to a shorter half-period toggles at once.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            main_cnt <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else if (sync_clr) begin
            main_cnt <= '0;
            clk_out  <= 1'b0;
            tick     <= 1'b0;
        end else if (!en) begin
            tick     <= 1'b0;
        end else if (main_cnt >= limit_last) begin
            main_cnt <= '0;
            clk_out  <= ~clk_out;
            tick     <= ~clk_out;
        end else begin
            main_cnt <= main_cnt + 1'b1;
            tick     <= 1'b0;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (sync_clr) begin
            blink_cnt <= '0;
            blink     <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink     <= ~blink;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_divisor_clock_prog.sv
// Scoreboard bench for divisor_clock_prog with HALF=10, HALF_FAST=2, HALF_BLINK=5;
// expected {clk_out,tick,blink} per posedge are derived from closed-form timing.
module tb_divisor_clock_prog;

    logic clk_in = 1'b0;
    logic rst = 1'b0;
    logic en = 1'b0;
    logic fast = 1'b0;
    logic sync_clr = 1'b0;
    logic clk_out;
    logic tick;
    logic blink;

    int compared = 0;
    int mismatched = 0;
    logic [2:0] sb[$];

    divisor_clock_prog #(
        .CLK_FREQ_HZ  (20),
        .OUT_FREQ_HZ  (1),
        .FAST_FACTOR  (5),
        .BLINK_FREQ_HZ(2)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .en      (en),
        .fast    (fast),
        .sync_clr(sync_clr),
        .clk_out (clk_out),
        .tick    (tick),
        .blink   (blink)
    );

    always #5 clk_in = ~clk_in;

    // Holds reset over a posedge, then releases it mid-cycle so posedge 1 is the first count.
    task automatic restart(input logic en_v, input logic fast_v);
        rst = 1'b0;
        en = en_v;
        fast = fast_v;
        sync_clr = 1'b0;
        @(posedge clk_in);
        @(negedge clk_in);
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] got;
        rst = 1'b0;
        #2;
        got = {clk_out, tick, blink};
        compared++;
        if (got !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL reset_initial: got %b expected 000", got);
        end
    endtask

    task automatic test_normal();
        logic [2:0] exp_v;
        logic [2:0] got;
        restart(1'b1, 1'b0);
        for (int k = 1; k <= 60; k++) begin
            exp_v = {1'((k / 10) % 2), 1'(k % 20 == 10), 1'((k / 5) % 2)};
            sb.push_back(exp_v);
            @(posedge clk_in);
            #1;
            exp_v = sb.pop_front();
            got = {clk_out, tick, blink};
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL normal k=%0d: got %b expected %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_pause();
        logic [2:0] exp_v;
        logic [2:0] got;
        int m;
        restart(1'b1, 1'b0);
        for (int k = 1; k <= 40; k++) begin
            en = (k >= 5 && k <= 11) ? 1'b0 : 1'b1;
            m = (k <= 4) ? k : ((k <= 11) ? 4 : k - 7);
            exp_v = {1'((m / 10) % 2), 1'((k <= 4 || k >= 12) && (m % 20 == 10)), 1'((k / 5) % 2)};
            sb.push_back(exp_v);
            @(posedge clk_in);
            #1;
            exp_v = sb.pop_front();
            got = {clk_out, tick, blink};
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL pause k=%0d: got %b expected %b", k, got, exp_v);
            end
        end
        en = 1'b1;
    endtask

    task automatic test_fast();
        logic [2:0] exp_v;
        logic [2:0] got;
        restart(1'b1, 1'b1);
        for (int k = 1; k <= 20; k++) begin
            exp_v = {1'((k / 2) % 2), 1'(k % 4 == 2), 1'((k / 5) % 2)};
            sb.push_back(exp_v);
            @(posedge clk_in);
            #1;
            exp_v = sb.pop_front();
            got = {clk_out, tick, blink};
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL fast k=%0d: got %b expected %b", k, got, exp_v);
            end
        end
        fast = 1'b0;
    endtask

    task automatic test_fast_switch();
        logic [2:0] exp_v;
        logic [2:0] got;
        int j;
        restart(1'b1, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            fast = (k >= 8) ? 1'b1 : 1'b0;
            j = k - 8;
            if (k < 8) exp_v = {2'b00, 1'((k / 5) % 2)};
            else       exp_v = {1'((j / 2) % 2 == 0), 1'(j % 4 == 0), 1'((k / 5) % 2)};
            sb.push_back(exp_v);
            @(posedge clk_in);
            #1;
            exp_v = sb.pop_front();
            got = {clk_out, tick, blink};
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL fast_switch k=%0d: got %b expected %b", k, got, exp_v);
            end
        end
        fast = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [2:0] exp_v;
        logic [2:0] got;
        restart(1'b1, 1'b0);
        for (int k = 1; k <= 17; k++) begin
            exp_v = {1'((k / 10) % 2), 1'(k % 20 == 10), 1'((k / 5) % 2)};
            sb.push_back(exp_v);
            @(posedge clk_in);
            #1;
            exp_v = sb.pop_front();
            got = {clk_out, tick, blink};
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL pre_reset k=%0d: got %b expected %b", k, got, exp_v);
            end
        end
        #1;
        rst = 1'b0;
        #1;
        got = {clk_out, tick, blink};
        compared++;
        if (got !== 3'b000) begin
            mismatched++;
            $display("[TB] FAIL async_reset: got %b expected 000", got);
        end
        @(negedge clk_in);
        rst = 1'b1;
        for (int k = 1; k <= 25; k++) begin
            exp_v = {1'((k / 10) % 2), 1'(k % 20 == 10), 1'((k / 5) % 2)};
            sb.push_back(exp_v);
            @(posedge clk_in);
            #1;
            exp_v = sb.pop_front();
            got = {clk_out, tick, blink};
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL post_reset k=%0d: got %b expected %b", k, got, exp_v);
            end
        end
    endtask

    task automatic test_sync_clr();
        logic [2:0] exp_v;
        logic [2:0] got;
        int j;
        restart(1'b1, 1'b0);
        for (int k = 1; k <= 43; k++) begin
            en = (k == 18) ? 1'b0 : 1'b1;
            sync_clr = (k == 18) ? 1'b1 : 1'b0;
            j = k - 18;
            if (k < 18)       exp_v = {1'((k / 10) % 2), 1'(k % 20 == 10), 1'((k / 5) % 2)};
            else if (k == 18) exp_v = 3'b000;
            else              exp_v = {1'((j / 10) % 2), 1'(j % 20 == 10), 1'((j / 5) % 2)};
            sb.push_back(exp_v);
            @(posedge clk_in);
            #1;
            exp_v = sb.pop_front();
            got = {clk_out, tick, blink};
            compared++;
            if (got !== exp_v) begin
                mismatched++;
                $display("[TB] FAIL sync_clr k=%0d: got %b expected %b", k, got, exp_v);
            end
        end
        sync_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_normal();
        test_pause();
        test_fast();
        test_fast_switch();
        test_async_reset();
        test_sync_clr();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
